rv32_mem_subword_bridge: RTL

//  Sits between the RV32I multicycle core's memory port and a word-only synchronous RAM bank.

---
 rtl/rv32_mem_subword_bridge_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 45 ++++
 rtl/rv32_mem_subword_bridge.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rv32_mem_subword_bridge_pkg.sv
// Shared types for the RV32I sub-word memory bridge: access size, exception mask
// and the bridge controller state encoding.
package rv32_mem_subword_bridge_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef logic [1:0] mem_exception_mask_t;

    localparam int unsigned MEM_EXCEPTION_ADDR_MISALIGNED = 0;
    localparam int unsigned MEM_EXCEPTION_ADDR_OOB        = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } bridge_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling for word-wide memories: load extract/extend and
// store lane merge, keyed by the low address bits and the access size.
module mem_lane_align
    import rv32_mem_subword_bridge_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_access_t access,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane   = rd_word[{addr_lo, 3'b000} +: 8];
        half_lane   = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        load_data   = rd_word;
        merged_word = wr_data;
        case (access)
            MEM_ACCESS_BYTE: begin
                load_data = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
                merged_word = rd_word;
                merged_word[{addr_lo, 3'b000} +: 8] = wr_data[7:0];
            end
            MEM_ACCESS_HALF: begin
                load_data = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
                merged_word = rd_word;
                if (addr_lo[1]) begin
                    merged_word[31:16] = wr_data[15:0];
                end else begin
                    merged_word[15:0] = wr_data[15:0];
                end
            end
            default: begin
                load_data   = rd_word;
                merged_word = wr_data;
            end
        endcase
    end

endmodule

// File: rtl/rv32_mem_subword_bridge.sv
// Bridges the core's byte/half/word memory port onto a word-only synchronous RAM,
// doing sub-word stores as read-modify-write and rejecting faulting addresses.
//
// state  | meaning
// S_IDLE | ready for a request; faults are decided here
// S_RD   | RAM word address presented for read
// S_CAP  | RAM read data valid; extract load lane or build merged store word
// S_WR   | single-cycle RAM write strobe
// S_RESP | core_done pulse with data/exception
module rv32_mem_subword_bridge
    import rv32_mem_subword_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 1024,
    localparam int         ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    output logic                core_ready,
    input  logic [31:0]         core_addr,
    input  logic                core_wr_ena,
    input  logic [31:0]         core_wr_data,
    input  mem_access_t         core_access,
    input  logic                core_unsigned,
    output logic [31:0]         core_rd_data,
    output logic                core_done,
    output mem_exception_mask_t core_exception,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [31:0]         ram_rd_data,
    output logic [31:0]         ram_wr_data,
    output logic                ram_wr_ena
);

    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    bridge_state_t       state_q, state_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    mem_access_t         access_q, access_d;
    logic                wr_ena_q, wr_ena_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                unsigned_q, unsigned_d;
    logic [31:0]         rd_data_q, rd_data_d;
    mem_exception_mask_t exc_q, exc_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wr_data_q, ram_wr_data_d;

    logic [31:0] offset;
    logic        misaligned;
    logic        oob;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    mem_lane_align u_lane_align (
        .addr_lo     (addr_lo_q),
        .access      (access_q),
        .is_unsigned (unsigned_q),
        .rd_word     (ram_rd_data),
        .wr_data     (wr_data_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        offset = core_addr - BASE_ADDR;
        oob    = ({1'b0, offset} >= SPAN_BYTES);
        case (core_access)
            MEM_ACCESS_BYTE: misaligned = 1'b0;
            MEM_ACCESS_HALF: misaligned = core_addr[0];
            MEM_ACCESS_WORD: misaligned = (core_addr[1:0] != 2'b00);
            default:         misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        addr_lo_d     = addr_lo_q;
        access_d      = access_q;
        wr_ena_d      = wr_ena_q;
        wr_data_d     = wr_data_q;
        unsigned_d    = unsigned_q;
        rd_data_d     = rd_data_q;
        exc_d         = exc_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    addr_lo_d  = core_addr[1:0];
                    access_d   = core_access;
                    wr_ena_d   = core_wr_ena;
                    wr_data_d  = core_wr_data;
                    unsigned_d = core_unsigned;
                    if (misaligned || oob) begin
                        // Response fields only change on entry to S_RESP so they hold between strobes.
                        rd_data_d = '0;
                        exc_d     = '0;
                        exc_d[MEM_EXCEPTION_ADDR_MISALIGNED] = misaligned;
                        exc_d[MEM_EXCEPTION_ADDR_OOB]        = oob;
                        state_d   = S_RESP;
                    end else begin
                        ram_addr_d = offset[ADDR_W+1:2];
                        if (core_wr_ena && core_access == MEM_ACCESS_WORD) begin
                            ram_wr_data_d = core_wr_data;
                            state_d       = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (wr_ena_q) begin
                    ram_wr_data_d = merged_word;
                    state_d       = S_WR;
                end else begin
                    rd_data_d = load_data;
                    exc_d     = '0;
                    state_d   = S_RESP;
                end
            end
            S_WR: begin
                rd_data_d = '0;
                exc_d     = '0;
                state_d   = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            addr_lo_q     <= '0;
            access_q      <= MEM_ACCESS_BYTE;
            wr_ena_q      <= 1'b0;
            wr_data_q     <= '0;
            unsigned_q    <= 1'b0;
            rd_data_q     <= '0;
            exc_q         <= '0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_lo_q     <= addr_lo_d;
            access_q      <= access_d;
            wr_ena_q      <= wr_ena_d;
            wr_data_q     <= wr_data_d;
            unsigned_q    <= unsigned_d;
            rd_data_q     <= rd_data_d;
            exc_q         <= exc_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
        end
    end

    assign core_ready     = (state_q == S_IDLE);
    assign core_done      = (state_q == S_RESP);
    assign ram_wr_ena     = (state_q == S_WR);
    assign core_rd_data   = rd_data_q;
    assign core_exception = exc_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wr_data    = ram_wr_data_q;

endmodule
